// File: rtl/sigma_delta_mod2.sv
// Second-order single-bit sigma-delta modulator with saturating integrators
// and an overload monitor that forces integrator recovery after sustained clipping.
// Optional TPDF-like LFSR dither is compiled in when SDM_DITHER_EN is defined.
module sigma_delta_mod2 #(
    parameter int unsigned IN_W      = 16,
    parameter int unsigned INT_W     = 20,
    parameter int unsigned OVL_LIMIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_enable,
    input  logic [IN_W-1:0] input_data,
    input  logic            input_valid,
    input  logic            ovl_clear,
    output logic            dac_out,
    output logic            ce_out,
    output logic            overload
);

    localparam int unsigned SUM_W = INT_W + 2;
    localparam int unsigned CNT_W = 8;

    localparam logic [CNT_W-1:0]        CNT_LIMIT = CNT_W'(OVL_LIMIT);
    localparam logic signed [INT_W-1:0] I_MAX     = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0] I_MIN     = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] S_MAX     = SUM_W'(I_MAX);
    localparam logic signed [SUM_W-1:0] S_MIN     = SUM_W'(I_MIN);
    localparam logic signed [SUM_W-1:0] FB        = SUM_W'({1'b1, {(IN_W-1){1'b0}}});

    logic signed [IN_W-1:0]  x_reg;
    logic signed [INT_W-1:0] i1;
    logic signed [INT_W-1:0] i2;
    logic [CNT_W-1:0]        ovl_cnt;

    logic signed [SUM_W-1:0] v_c;
    logic signed [SUM_W-1:0] d_c;
    logic signed [SUM_W-1:0] sum1_c;
    logic signed [SUM_W-1:0] sum2_c;
    logic signed [INT_W-1:0] i1n_c;
    logic signed [INT_W-1:0] i2n_c;
    logic                    sat1_c;
    logic                    sat2_c;
    logic                    force_c;

`ifdef SDM_DITHER_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, advanced once per update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else if (clk_enable) begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    assign d_c = SUM_W'($signed(lfsr[3:0]));
`else
    assign d_c = '0;
`endif

    // Integrator sums at full width, clamped back to the integrator range
    always_comb begin
        v_c    = dac_out ? FB : -FB;
        sum1_c = SUM_W'(i1) + SUM_W'(x_reg) - v_c;
        sat1_c = (sum1_c > S_MAX) || (sum1_c < S_MIN);
        i1n_c  = sum1_c[INT_W-1:0];
        if (sat1_c) begin
            i1n_c = (sum1_c > S_MAX) ? I_MAX : I_MIN;
        end
        sum2_c = SUM_W'(i2) + SUM_W'(i1n_c) - v_c + d_c;
        sat2_c = (sum2_c > S_MAX) || (sum2_c < S_MIN);
        i2n_c  = sum2_c[INT_W-1:0];
        if (sat2_c) begin
            i2n_c = (sum2_c > S_MAX) ? I_MAX : I_MIN;
        end
        force_c = clk_enable && (ovl_cnt == CNT_LIMIT);
    end

    // Sample capture from the interpolator, independent of the update strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg <= '0;
        end else if (input_valid) begin
            x_reg <= input_data;
        end
    end

    // Modulator state update, or forced recovery once clipping has persisted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i1      <= '0;
            i2      <= '0;
            dac_out <= 1'b1;
            ovl_cnt <= '0;
        end else if (clk_enable) begin
            if (ovl_cnt == CNT_LIMIT) begin
                i1      <= '0;
                i2      <= '0;
                dac_out <= 1'b1;
                ovl_cnt <= '0;
            end else begin
                i1      <= i1n_c;
                i2      <= i2n_c;
                dac_out <= (i2n_c >= 0);
                ovl_cnt <= (sat1_c || sat2_c) ? ovl_cnt + CNT_W'(1) : '0;
            end
        end
    end

    // Sticky overload flag; a forced clear outranks a simultaneous clear request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overload <= 1'b0;
        end else if (force_c) begin
            overload <= 1'b1;
        end else if (ovl_clear) begin
            overload <= 1'b0;
        end
    end

    // Output strobe marks the cycle a fresh dac_out is presented
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ce_out <= 1'b0;
        end else begin
            ce_out <= clk_enable;
        end
    end

endmodule

// File: tb/tb_sigma_delta_mod2.sv
// Bench for sigma_delta_mod2: a default instance (INT_W=20, OVL_LIMIT=15) and
// a small overload instance (INT_W=17, OVL_LIMIT=2) run against a behavioural model.
module tb_sigma_delta_mod2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        en_a, vld_a, clr_a, dac_a, ce_a, ovl_a;
    logic [15:0] data_a;
    logic        en_b, vld_b, clr_b, dac_b, ce_b, ovl_b;
    logic [15:0] data_b;

    sigma_delta_mod2 #(.IN_W(16), .INT_W(20), .OVL_LIMIT(15)) dut_a (
        .clk(clk), .reset(reset), .clk_enable(en_a), .input_data(data_a),
        .input_valid(vld_a), .ovl_clear(clr_a), .dac_out(dac_a), .ce_out(ce_a),
        .overload(ovl_a)
    );

    sigma_delta_mod2 #(.IN_W(16), .INT_W(17), .OVL_LIMIT(2)) dut_b (
        .clk(clk), .reset(reset), .clk_enable(en_b), .input_data(data_b),
        .input_valid(vld_b), .ovl_clear(clr_b), .dac_out(dac_b), .ce_out(ce_b),
        .overload(ovl_b)
    );

    typedef struct {
        longint      i1;
        longint      i2;
        bit          dac;
        int          cnt;
        bit          ovl;
        longint      x;
        logic [15:0] lfsr;
    } mstate_t;

    int      checks = 0;
    int      errors = 0;
    int      ones_a = 0;
    mstate_t ma, mb;
    bit      qa[$];
    bit      qb[$];

    function automatic mstate_t m_reset();
        mstate_t s;
        s.i1 = 0; s.i2 = 0; s.dac = 1'b1; s.cnt = 0; s.ovl = 1'b0; s.x = 0;
        s.lfsr = 16'hACE1;
        return s;
    endfunction

    function automatic longint clampw(input longint v, input int w);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -(longint'(1) <<< (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic mstate_t mstep(input mstate_t s, input bit en, input bit vld,
                                      input longint data, input bit clr,
                                      input int w, input int lim);
        mstate_t n = s;
        longint  v, a, b, d;
        bit      set = 1'b0;
        d = 0;
        if (en) begin
`ifdef SDM_DITHER_EN
            d = longint'($signed(s.lfsr[3:0]));
            n.lfsr = {s.lfsr[0] ^ s.lfsr[2] ^ s.lfsr[3] ^ s.lfsr[5], s.lfsr[15:1]};
`endif
            if (s.cnt == lim) begin
                n.i1 = 0; n.i2 = 0; n.dac = 1'b1; n.cnt = 0; set = 1'b1;
            end else begin
                v = s.dac ? 32768 : -32768;
                a = s.i1 + s.x - v;
                b = s.i2 + clampw(a, w) - v + d;
                n.i1  = clampw(a, w);
                n.i2  = clampw(b, w);
                n.dac = (n.i2 >= 0);
                n.cnt = (n.i1 != a || n.i2 != b) ? s.cnt + 1 : 0;
            end
        end
        if (vld) n.x = data;
        if (set) n.ovl = 1'b1;
        else if (clr) n.ovl = 1'b0;
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive both instances, advance models, check after the edge
    task automatic tick(input bit ea, input bit va, input int da, input bit ca,
                        input bit eb, input bit vb, input int db, input bit cb);
        bit e;
        en_a = ea; vld_a = va; data_a = 16'(da); clr_a = ca;
        en_b = eb; vld_b = vb; data_b = 16'(db); clr_b = cb;
        @(posedge clk);
        ma = mstep(ma, ea, va, longint'($signed(data_a)), ca, 20, 15);
        mb = mstep(mb, eb, vb, longint'($signed(data_b)), cb, 17, 2);
        if (ea) qa.push_back(ma.dac);
        if (eb) qb.push_back(mb.dac);
        #1;
        check("a_ce", ce_a, ea);
        if (ce_a === 1'b1) begin
            check("a_sb_depth", qa.size(), 1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check("a_dac", dac_a, e);
            end
        end else begin
            check("a_dac_hold", dac_a, ma.dac);
        end
        check("b_ce", ce_b, eb);
        if (ce_b === 1'b1) begin
            check("b_sb_depth", qb.size(), 1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check("b_dac", dac_b, e);
            end
        end else begin
            check("b_dac_hold", dac_b, mb.dac);
        end
        check("a_ovl", ovl_a, ma.ovl);
        check("b_ovl", ovl_b, mb.ovl);
        check("a_i1", longint'(dut_a.i1), ma.i1);
        check("a_i2", longint'(dut_a.i2), ma.i2);
        check("b_i1", longint'(dut_b.i1), mb.i1);
        check("b_i2", longint'(dut_b.i2), mb.i2);
        if (ea && dac_a === 1'b1) ones_a++;
    endtask

    // Asynchronous reset between clock edges; outputs must clear immediately
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_dac_a", dac_a, 1'b1);
        check("rst_ce_a", ce_a, 1'b0);
        check("rst_ovl_a", ovl_a, 1'b0);
        check("rst_dac_b", dac_b, 1'b1);
        check("rst_ce_b", ce_b, 1'b0);
        check("rst_ovl_b", ovl_b, 1'b0);
        ma = m_reset();
        mb = m_reset();
        qa.delete();
        qb.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle_b_update(input bit clr);
        tick(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, -32768, clr);
    endtask

    initial begin
        bit     pat[8];
        longint i1_pre;
        bit     dac_pre;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        reset = 1'b1;
        en_a = 0; vld_a = 0; clr_a = 0; data_a = '0;
        en_b = 0; vld_b = 0; clr_b = 0; data_b = '0;
        ma = m_reset();
        mb = m_reset();
        #2;
        do_reset();

        // Zero input stream
        ones_a = 0;
        for (int i = 0; i < 1024; i++) begin
            tick(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
`ifndef SDM_DITHER_EN
            if (i < 7) check("zero_pat", dac_a, pat[i + 1]);
`endif
        end
`ifndef SDM_DITHER_EN
        check("zero_ones", ones_a, 512);
`endif

        // Enable gap with a sample captured in the middle of it
        tick(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        i1_pre  = ma.i1;
        dac_pre = ma.dac;
        tick(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        tick(1'b0, 1'b1, 12345, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("gap_i1_hold", longint'(dut_a.i1), i1_pre);
        check("gap_dac_hold", dac_a, dac_pre);
        tick(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("gap_new_x", longint'(dut_a.i1), i1_pre + 12345 - (dac_pre ? 32768 : -32768));

        // Overload on the narrow instance with full negative input
        tick(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, -32768, 1'b0);
        idle_b_update(1'b0);
        check("ovl_i2_sat", longint'(dut_b.i2), -65536);
        check("ovl_u1", ovl_b, 1'b0);
        idle_b_update(1'b0);
        check("ovl_u2", ovl_b, 1'b0);
        idle_b_update(1'b0);
        check("ovl_u3_set", ovl_b, 1'b1);
        check("ovl_u3_i1", longint'(dut_b.i1), 0);
        check("ovl_u3_i2", longint'(dut_b.i2), 0);
        check("ovl_u3_dac", dac_b, 1'b1);
        idle_b_update(1'b1);
        check("ovl_clear", ovl_b, 1'b0);
        idle_b_update(1'b0);
        idle_b_update(1'b1);
        check("ovl_set_wins", ovl_b, 1'b1);
        tick(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        check("ovl_clear_idle", ovl_b, 1'b0);
        for (int i = 0; i < 3; i++) idle_b_update(1'b0);
        check("ovl_reset_again", ovl_b, 1'b1);

        // Mid-stream reset, then the zero-input sequence restarts
        tick(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
`ifndef SDM_DITHER_EN
            check("rst_pat", dac_a, pat[i + 1]);
`endif
        end

        // Half-scale positive and negative
        do_reset();
        tick(1'b0, 1'b1, 16384, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        ones_a = 0;
        for (int i = 0; i < 4096; i++) tick(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("half_pos_ones", (ones_a >= 3068 && ones_a <= 3076), 1'b1);
        do_reset();
        tick(1'b0, 1'b1, -16384, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        ones_a = 0;
        for (int i = 0; i < 4096; i++) tick(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("half_neg_ones", (ones_a >= 1020 && ones_a <= 1028), 1'b1);

`ifdef SDM_DITHER_EN
        // Dithered zero input
        do_reset();
        ones_a = 0;
        tick(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("lfsr_1", dut_a.lfsr, 16'h5670);
        for (int i = 1; i < 4096; i++) tick(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("dither_ones", (ones_a >= 2032 && ones_a <= 2064), 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sigma_delta_mod2.md
# sigma_delta_mod2

Second-order single-bit sigma-delta modulator that consumes the 16-bit interpolated sample stream from `interpolatingFilter` and produces the 1-bit DAC bitstream. It captures each new sample on the filter's sample strobe and runs two saturating integrators with a 1-bit quantiser on every enabled clock. An overload monitor detects sustained integrator saturation, forces recovery and reports it.

## Interface
- `IN_W`, 16: input sample width, signed.
- `INT_W`, 20: integrator width, signed; must be ≥ IN_W+2.
- `OVL_LIMIT`, 15: consecutive saturating updates before a forced integrator clear; range 1..255.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; all state is cleared on assertion.
- `clk_enable`  in  1  modulator update strobe; one bit-period per high cycle.
- `input_data`  in  IN_W  signed sample from the interpolating filter.
- `input_valid`  in  1  sample strobe; driven by the filter's `ce_out`.
- `ovl_clear`  in  1  synchronous clear of the sticky `overload` flag.
- `dac_out`  out  1  registered bitstream; 1 selects +FS, 0 selects −FS.
- `ce_out`  out  1  high in the cycle a new `dac_out` value is presented.
- `overload`  out  1  sticky: a forced integrator clear has occurred.

## Operation
- FB = 2^(IN_W−1), which is 32768 at the default width. v = +FB when `dac_out`=1, and −FB otherwise.
- **Input capture.** `x_reg` <= `input_data` on any cycle with `input_valid`=1, independent of `clk_enable`. `x_reg` is sign-extended to INT_W.
- **Update.** The update runs only on cycles with `clk_enable`=1. It uses the values held before the edge:
  - i1n = sat(i1 + x_reg − v)
  - i2n = sat(i2 + i1n − v + d)
  - i1 <= i1n, i2 <= i2n
  - `dac_out` <= (i2n ≥ 0)
  - d is the dither term, 0 unless dither is compiled in.
- **Saturation.** Each sum is computed at full width (INT_W+2 bits) and clamped to [−2^(INT_W−1), 2^(INT_W−1)−1]. "Saturated" means that clamping changed the value.
- **Overload counter.** `ovl_cnt` is evaluated on update cycles only:
  - If `ovl_cnt` = OVL_LIMIT: i1 <= 0, i2 <= 0, `dac_out` <= 1, `ovl_cnt` <= 0 and `overload` <= 1. The normal update is discarded for that cycle.
  - Otherwise, if either integrator saturated in this update: `ovl_cnt` <= `ovl_cnt` + 1.
  - Otherwise: `ovl_cnt` <= 0.
- **Overload flag.** `overload` is cleared by `ovl_clear`=1 on any cycle. If a set and a clear occur in the same cycle, the set wins.
- **Disabled cycles.** With `clk_enable`=0, i1, i2, `dac_out`, `ovl_cnt` and the LFSR all hold.

## Timing
- Reset values: i1=0, i2=0, `x_reg`=0, `ovl_cnt`=0, `dac_out`=1, `ce_out`=0, `overload`=0. The LFSR is reset to 16'hACE1.
- `ce_out` <= `clk_enable` (registered). `ce_out` is therefore high exactly when `dac_out` has just updated.
- Latency: with `input_valid` at edge N and `clk_enable`=1 continuously, the sample first affects i1, i2 and `dac_out` at edge N+1. It is visible on `dac_out` after N+1.
- A sample arriving in the same cycle as an update is not used by that update; the update uses the previous `x_reg`.
- Reset asserted mid-stream returns all state to reset values immediately. The first update after deassertion behaves identically to a first update after power-up.

## Configuration
- `SDM_DITHER_EN` defined:
  - Adds a 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, seeded 16'hACE1.
  - The LFSR advances once per update cycle.
  - d = lfsr[3:0] interpreted as signed 4-bit (−8..7), sign-extended.
- Not defined: d = 0 and no LFSR logic is generated. Output is bit-exact to the undithered equations.

## Test plan
- **Reset:** assert `reset` mid-stream -> `dac_out`=1, `ce_out`=0 and `overload`=0 in the same cycle. After release, the zero-input sequence restarts from 1,0,0,1,1,0,0,1.
- **Zero input, no dither:** `input_data`=0 and `clk_enable`=1 for 1024 cycles -> `dac_out` follows the period-4 pattern 1,0,0,1,… with exactly 512 ones.
- **Half-scale:** `input_data`=+16384 held for 4096 updates -> the count of ones is 3072±4. With `input_data`=−16384 -> 1024±4.
- **Gaps:** `clk_enable` toggled 1,0,0,1, with `input_valid` pulsed during a gap -> `dac_out` and the integrators hold through the gap, and `ce_out` is low there. The new sample is used from the next update.
- **Overload:** INT_W=17, OVL_LIMIT=2, `input_data`=−32768 held -> i2 saturates on the first update. `overload` rises on the 3rd update and i1/i2 read 0 after it. Then pulse `ovl_clear` -> `overload`=0, unless a set occurs in the same cycle.
- **Dither (`SDM_DITHER_EN`):** zero input for 4096 updates -> the period-4 tone is broken and the count of ones is 2048±16. The LFSR state after 1 update is 16'h5670.
